// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS core. It sequences the shared ALU, the unified memory port and the register file.
// Latency: instructions take 3-5 cycles (BEQ/J 3; SW/R/ADDI 4; LW 5). Each memory wait cycle adds one.
// Backpressure: mem_ready stalls FETCH, MEMRD and MEMWR. TRAP holds until rst.
// Ports: clk/rst (sync, active-high); opcode, mem_ready and alu_err in; the datapath mux selects,
//        the write strobes, instr_done and the sticky illegal_instr out.

package mips_ctrl_pkg;
    typedef enum logic [1:0] {
        ADD_Op    = 2'b00,
        SUB_Op    = 2'b01,
        R_Type_Op = 2'b10
    } alu_op_t;
endpackage

module mips_multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_err,
    output alu_op_t    alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       pc_write,
    output logic       branch,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal_instr
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
    } state_t;

    // Per-state control word. The fields qualified by mem_ready are kept as
    // flags and are combined with mem_ready at the output:
    // fetch    -> ir_write/pc_write
    // mem_write -> the retire pulse of a store
    typedef struct packed {
        alu_op_t    alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       fetch;
        logic       jump_pc;
        logic       branch;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       done;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c        = '0;
        c.alu_op = ADD_Op;
        case (s)
            S_FETCH: begin
                c.alu_src_b = 2'b01;
                c.fetch     = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'b11;  // precompute the branch target
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done       = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = R_Type_Op;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.done      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = SUB_Op;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
                c.done      = 1'b1;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_JUMP: begin
                c.pc_src  = 2'b10;
                c.jump_pc = 1'b1;
                c.done    = 1'b1;
            end
            S_TRAP:  c.illegal = 1'b1;
            default: c.illegal = 1'b0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            // Only loads and stores reach this state. Anything else here
            // would mean a corrupted IR, so it traps rather than guessing.
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_TRAP;
            end
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = alu_err ? S_TRAP : S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    // The outputs are registered from the next state, so ctrl_q always matches state_q.
    always_comb ctrl_d = decode_state(state_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_state(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Reset masks every output combinationally. This stays true while rst is held,
    // even though the state has already moved to FETCH.
    always_comb begin
        alu_op        = ADD_Op;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        iord          = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        if (!rst) begin
            alu_op        = ctrl_q.alu_op;
            alu_src_a     = ctrl_q.alu_src_a;
            alu_src_b     = ctrl_q.alu_src_b;
            pc_src        = ctrl_q.pc_src;
            iord          = ctrl_q.iord;
            ir_write      = ctrl_q.fetch & mem_ready;
            pc_write      = (ctrl_q.fetch & mem_ready) | ctrl_q.jump_pc;
            branch        = ctrl_q.branch;
            mem_write     = ctrl_q.mem_write;
            reg_write     = ctrl_q.reg_write;
            reg_dst       = ctrl_q.reg_dst;
            mem_to_reg    = ctrl_q.mem_to_reg;
            instr_done    = ctrl_q.done | (ctrl_q.mem_write & mem_ready);
            illegal_instr = ctrl_q.illegal;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Testbench for mips_multicycle_controller: randomized instruction streams scored cycle by cycle.
// Latency: not applicable (bench).
// Backpressure: mem_ready wait cycles are inserted at random in FETCH, MEMRD and MEMWR.

module tb_mips_multicycle_controller;
    import mips_ctrl_pkg::*;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       pc_write;
        logic       branch;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal_instr;
    } outv_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       alu_err = 1'b0;
    alu_op_t    alu_op;
    logic       alu_src_a, iord, pc_write, branch, ir_write, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal_instr;
    logic [1:0] alu_src_b, pc_src;

    mips_multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .alu_err(alu_err),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .iord(iord), .pc_write(pc_write), .branch(branch), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    outv_t exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    // Expected outputs of one named instruction step, taken directly from the step table.
    function automatic outv_t ph(input string p, input bit mr);
        outv_t o;
        o        = '0;
        o.alu_op = ADD_Op;
        if (p == "FETCH") begin
            o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr;
        end else if (p == "DECODE") begin
            o.alu_src_b = 2'b11;
        end else if (p == "MEMADR" || p == "ADDIEX") begin
            o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        end else if (p == "MEMRD") begin
            o.iord = 1'b1;
        end else if (p == "MEMWB") begin
            o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
        end else if (p == "MEMWR") begin
            o.iord = 1'b1; o.mem_write = 1'b1; o.instr_done = mr;
        end else if (p == "EXECUTE") begin
            o.alu_src_a = 1'b1; o.alu_op = R_Type_Op;
        end else if (p == "ALUWB") begin
            o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
        end else if (p == "BRANCH") begin
            o.alu_src_a = 1'b1; o.alu_op = SUB_Op; o.pc_src = 2'b01;
            o.branch = 1'b1; o.instr_done = 1'b1;
        end else if (p == "ADDIWB") begin
            o.reg_write = 1'b1; o.instr_done = 1'b1;
        end else if (p == "JUMP") begin
            o.pc_src = 2'b10; o.pc_write = 1'b1; o.instr_done = 1'b1;
        end else if (p == "TRAP") begin
            o.illegal_instr = 1'b1;
        end
        return o;  // "RST": everything idle
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle of inputs and queue the response expected for that cycle.
    task automatic cyc(input string nm, input bit r, input bit mr, input bit err);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = mr;
        alu_err   = err;
        exp_q.push_back(ph(nm, mr));
        name_q.push_back(nm);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input bit err, input bit abort_rd);
        bit trapped;
        trapped = 1'b0;
        opcode  = op;
        repeat (fw) cyc("FETCH", 1'b0, 1'b0, rb());
        cyc("FETCH", 1'b0, 1'b1, rb());
        cyc("DECODE", 1'b0, rb(), rb());
        case (op)
            OP_LW: begin
                cyc("MEMADR", 1'b0, rb(), rb());
                if (abort_rd) begin
                    cyc("MEMRD", 1'b0, 1'b0, rb());
                    cyc("RST", 1'b1, rb(), rb());
                end else begin
                    repeat (mw) cyc("MEMRD", 1'b0, 1'b0, rb());
                    cyc("MEMRD", 1'b0, 1'b1, rb());
                    cyc("MEMWB", 1'b0, rb(), rb());
                end
            end
            OP_SW: begin
                cyc("MEMADR", 1'b0, rb(), rb());
                repeat (mw) cyc("MEMWR", 1'b0, 1'b0, rb());
                cyc("MEMWR", 1'b0, 1'b1, rb());
            end
            OP_R: begin
                cyc("EXECUTE", 1'b0, rb(), err);
                if (err) trapped = 1'b1;
                else     cyc("ALUWB", 1'b0, rb(), rb());
            end
            OP_BEQ:  cyc("BRANCH", 1'b0, rb(), rb());
            OP_ADDI: begin
                cyc("ADDIEX", 1'b0, rb(), rb());
                cyc("ADDIWB", 1'b0, rb(), rb());
            end
            OP_J:    cyc("JUMP", 1'b0, rb(), rb());
            default: trapped = 1'b1;
        endcase
        if (trapped) begin
            repeat (10 + $urandom_range(0, 3)) cyc("TRAP", 1'b0, rb(), rb());
            cyc("RST", 1'b1, rb(), rb());
        end
    endtask

    // Monitor: every sampled cycle is compared against the oldest queued expectation.
    outv_t mon_got, mon_exp;
    string mon_nm;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_got = '{alu_op, alu_src_a, alu_src_b, pc_src, iord, pc_write, branch, ir_write,
                        mem_write, reg_write, reg_dst, mem_to_reg, instr_done, illegal_instr};
            n_chk++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL %s @%0t: outputs got %h expected %h (reg_write=%b mem_write=%b done=%b)",
                         mon_nm, $time, mon_got, mon_exp, reg_write, mem_write, instr_done);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

        cyc("RST", 1'b1, 1'b0, 1'b0);
        cyc("RST", 1'b1, 1'b1, 1'b1);

        run_instr(OP_LW,   0, 0, 1'b0, 1'b0);  // zero-wait load, 5 cycles
        run_instr(OP_SW,   0, 2, 1'b0, 1'b0);  // store with 2 wait cycles
        run_instr(OP_R,    3, 0, 1'b0, 1'b0);  // 3 fetch waits
        run_instr(OP_R,    0, 0, 1'b1, 1'b0);  // unsupported function -> trap
        run_instr(OP_BEQ,  0, 0, 1'b0, 1'b0);
        run_instr(OP_J,    1, 0, 1'b0, 1'b0);
        run_instr(6'h3f,   0, 0, 1'b0, 1'b0);  // undefined opcode
        run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0);
        run_instr(OP_LW,   0, 0, 1'b0, 1'b1);  // reset while in MEMRD
        run_instr(OP_LW,   2, 2, 1'b0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                op = 6'($urandom);
                if (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) op = 6'h3f;
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2),
                      ($urandom_range(0, 7) == 0),
                      (op == OP_LW) && ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
